maint_cmd_issuer: RTL



---
 rtl/maint_cmd_issuer.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/maint_cmd_issuer.sv
`timescale 1ns/1ps
// maint_cmd_issuer: arbitrates refresh / ZQ / periodic-read maintenance requests, wins the DRAM
// command bus and issues PREA+REF, PREA+ZQCS or PRD. ZQ servicing is built only with MAINT_ISSUER_ZQ_EN.
module maint_cmd_issuer #(
  parameter int TCQ      = 100,
  parameter int tRP_CK   = 6,
  parameter int tRFC_CK  = 64,
  parameter int tZQCS_CK = 32,
  parameter int tPRD_CK  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dfi_init_complete,
  input  logic       autoref_req,
  input  logic       zq_req,
  input  logic       periodic_rd_req,
  output logic       autoref_ack,
  output logic       zq_ack,
  output logic       periodic_rd_ack,
  output logic       bus_req,
  input  logic       bus_gnt,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  output logic       maint_busy
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    BUS_WAIT = 3'd1,
    PRE      = 3'd2,
    RP_WAIT  = 3'd3,
    ISSUE    = 3'd4,
    HOLD     = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    SEL_REF = 2'd0,
    SEL_ZQ  = 2'd1,
    SEL_PRD = 2'd2
  } sel_t;

  localparam logic [2:0] CMD_NOP  = 3'b000;
  localparam logic [2:0] CMD_PREA = 3'b001;
  localparam logic [2:0] CMD_REF  = 3'b010;
  localparam logic [2:0] CMD_ZQCS = 3'b011;
  localparam logic [2:0] CMD_PRD  = 3'b100;

  localparam logic [7:0] RP_LOAD  = 8'(tRP_CK - 1);
  localparam logic [7:0] RFC_LOAD = 8'(tRFC_CK - 1);
  localparam logic [7:0] ZQ_LOAD  = 8'(tZQCS_CK - 1);
  localparam logic [7:0] PRD_LOAD = 8'(tPRD_CK - 1);

  // Registers carry no clock-to-out delay; an illegal TCQ or timing value shows up as this scope.
  if (TCQ < 0 || tRP_CK < 1 || tRP_CK > 255 || tRFC_CK < 1 || tRFC_CK > 255 ||
      tZQCS_CK < 1 || tZQCS_CK > 255 || tPRD_CK < 1 || tPRD_CK > 255) begin : g_bad_param
  end

  state_t     state_r;
  sel_t       sel_r;
  logic [7:0] cnt_r;
  logic       zq_pending_s;
  logic [2:0] issue_code_s;
  logic [2:0] issue_ack_s;
  logic [7:0] hold_load_s;
  logic [2:0] entry_code_s;
  logic [2:0] entry_ack_s;

`ifdef MAINT_ISSUER_ZQ_EN
  assign zq_pending_s = zq_req;
`else
  assign zq_pending_s = 1'b0;
`endif

  // Decode the latched request into its command, ack lane {ref,zq,prd} and hold count.
  always_comb begin
    issue_code_s = CMD_PRD;
    issue_ack_s  = 3'b001;
    hold_load_s  = PRD_LOAD;
    case (sel_r)
      SEL_REF: begin
        issue_code_s = CMD_REF;
        issue_ack_s  = 3'b100;
        hold_load_s  = RFC_LOAD;
      end
      SEL_ZQ: begin
        issue_code_s = CMD_ZQCS;
        issue_ack_s  = 3'b010;
        hold_load_s  = ZQ_LOAD;
      end
      default: begin
        issue_code_s = CMD_PRD;
        issue_ack_s  = 3'b001;
        hold_load_s  = PRD_LOAD;
      end
    endcase
    if (bus_gnt) begin
      entry_code_s = issue_code_s;
      entry_ack_s  = issue_ack_s;
    end else begin
      entry_code_s = CMD_NOP;
      entry_ack_s  = 3'b000;
    end
  end

  // Sequencer FSM; outputs are registered together with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= IDLE;
      sel_r           <= SEL_REF;
      cnt_r           <= 8'd0;
      bus_req         <= 1'b0;
      cmd_valid       <= 1'b0;
      cmd_code        <= CMD_NOP;
      autoref_ack     <= 1'b0;
      zq_ack          <= 1'b0;
      periodic_rd_ack <= 1'b0;
      maint_busy      <= 1'b0;
    end else if (!dfi_init_complete) begin
      state_r         <= IDLE;
      bus_req         <= 1'b0;
      cmd_valid       <= 1'b0;
      cmd_code        <= CMD_NOP;
      autoref_ack     <= 1'b0;
      zq_ack          <= 1'b0;
      periodic_rd_ack <= 1'b0;
      maint_busy      <= 1'b0;
    end else begin
      cmd_valid                                <= 1'b0;
      cmd_code                                 <= CMD_NOP;
      {autoref_ack, zq_ack, periodic_rd_ack}   <= 3'b000;
      case (state_r)
        IDLE: begin
          if (autoref_req || zq_pending_s || periodic_rd_req) begin
            sel_r      <= autoref_req ? SEL_REF : (zq_pending_s ? SEL_ZQ : SEL_PRD);
            state_r    <= BUS_WAIT;
            bus_req    <= 1'b1;
            maint_busy <= 1'b1;
          end else begin
            bus_req    <= 1'b0;
            maint_busy <= 1'b0;
          end
`ifndef MAINT_ISSUER_ZQ_EN
          zq_ack <= zq_req & ~zq_ack;
`endif
        end
        BUS_WAIT: begin
          if (bus_gnt) begin
            cmd_valid <= 1'b1;
            if (sel_r == SEL_PRD) begin
              state_r                              <= ISSUE;
              cmd_code                             <= entry_code_s;
              {autoref_ack, zq_ack, periodic_rd_ack} <= entry_ack_s;
            end else begin
              state_r  <= PRE;
              cmd_code <= CMD_PREA;
            end
          end
        end
        PRE: begin
          // cmd_valid high here means the PREA strobe already went out under grant.
          if (cmd_valid) begin
            if (RP_LOAD == 8'd0) begin
              state_r                              <= ISSUE;
              cmd_valid                            <= bus_gnt;
              cmd_code                             <= entry_code_s;
              {autoref_ack, zq_ack, periodic_rd_ack} <= entry_ack_s;
            end else begin
              state_r <= RP_WAIT;
              cnt_r   <= RP_LOAD;
            end
          end else if (bus_gnt) begin
            cmd_valid <= 1'b1;
            cmd_code  <= CMD_PREA;
          end
        end
        RP_WAIT: begin
          cnt_r <= cnt_r - 8'd1;
          if (cnt_r == 8'd1) begin
            state_r                              <= ISSUE;
            cmd_valid                            <= bus_gnt;
            cmd_code                             <= entry_code_s;
            {autoref_ack, zq_ack, periodic_rd_ack} <= entry_ack_s;
          end
        end
        ISSUE: begin
          if (cmd_valid) begin
            if (hold_load_s == 8'd0) begin
              state_r    <= IDLE;
              bus_req    <= 1'b0;
              maint_busy <= 1'b0;
            end else begin
              state_r <= HOLD;
              cnt_r   <= hold_load_s;
            end
          end else if (bus_gnt) begin
            cmd_valid                            <= 1'b1;
            cmd_code                             <= issue_code_s;
            {autoref_ack, zq_ack, periodic_rd_ack} <= issue_ack_s;
          end
        end
        HOLD: begin
          cnt_r <= cnt_r - 8'd1;
          if (cnt_r == 8'd1) begin
            state_r    <= IDLE;
            bus_req    <= 1'b0;
            maint_busy <= 1'b0;
          end
        end
        default: begin
          state_r    <= IDLE;
          bus_req    <= 1'b0;
          maint_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
